// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding word reads and
// buffers returned instructions for decode. Optional FETCH_PERF_CNT_EN adds perf counters.
module fetch_unit #(
  parameter int                  PC_WIDTH   = 16,
  parameter int                  INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
  parameter int                  BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  redirect,
  input  logic                  jump_address,
  input  logic [PC_WIDTH-1:0]   jump_imm_target,
  input  logic [PC_WIDTH-1:0]   jump_reg_target,
  output logic                  imem_req,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic                  imem_ack,
  input  logic [INST_WIDTH-1:0] imem_data,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [INST_WIDTH-1:0] inst,
  output logic [PC_WIDTH-1:0]   inst_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           perf_redirects,
  output logic [31:0]           perf_bubbles
`endif
);

  localparam int PTR_W = (BUF_DEPTH > 2) ? 2 : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [PC_WIDTH-1:0]   pc;
  logic                  discard;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      occupancy;
  logic [INST_WIDTH-1:0] buf_inst [BUF_DEPTH];
  logic [PC_WIDTH-1:0]   buf_pc   [BUF_DEPTH];
  logic [INST_WIDTH-1:0] hold_inst;
  logic [PC_WIDTH-1:0]   hold_pc;
  logic [PC_WIDTH-1:0]   target;
  logic                  ack_vld;
  logic                  push;
  logic                  pop;
  logic                  issue;

  assign target     = jump_address ? jump_imm_target : jump_reg_target;
  assign ack_vld    = imem_req & imem_ack;
  assign inst_valid = (count != '0);
  assign occupancy  = count + CNT_W'(imem_req);

  // Redirect cancels both the incoming response and any same-cycle pop.
  assign push  = ack_vld & ~discard & ~redirect;
  assign pop   = inst_valid & inst_ready & ~redirect;
  assign issue = ~imem_req & ~redirect & (occupancy < CNT_W'(BUF_DEPTH));

  // Empty buffer shows the last head presented rather than stale storage.
  assign inst    = inst_valid ? buf_inst[rd_ptr] : hold_inst;
  assign inst_pc = inst_valid ? buf_pc[rd_ptr]   : hold_pc;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc        <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      discard   <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      hold_inst <= '0;
      hold_pc   <= '0;
    end else begin
      if (redirect) begin
        pc     <= target;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        // A response still in flight belongs to the wrong path.
        if (imem_req) begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            discard  <= 1'b0;
          end else begin
            discard  <= 1'b1;
          end
        end
      end else begin
        if (issue) begin
          imem_req  <= 1'b1;
          imem_addr <= pc;
          pc        <= pc + PC_WIDTH'(1);
        end else if (ack_vld) begin
          imem_req <= 1'b0;
          discard  <= 1'b0;
        end
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (!push && pop) count <= count - CNT_W'(1);
      end
      if (inst_valid) begin
        hold_inst <= buf_inst[rd_ptr];
        hold_pc   <= buf_pc[rd_ptr];
      end
    end
  end

  // Buffer storage carries data only; occupancy is tracked by the control above.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_inst[wr_ptr] <= imem_data;
      buf_pc[wr_ptr]   <= imem_addr;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perf_redirects <= '0;
      perf_bubbles   <= '0;
    end else begin
      if (redirect)                  perf_redirects <= perf_redirects + 32'd1;
      if (inst_ready && !inst_valid) perf_bubbles   <= perf_bubbles + 32'd1;
    end
  end
`endif

endmodule
